reaction_round_ctrl: RTL and testbench

Session sequencer for the reaction-time tester. It runs ROUNDS stimulus/response rounds back to back, driving the delay generator start, the BCD millisecond counter clear and enable, and the fault and timeout reporting. It tracks the best (minimum) BCD reaction time across the session and presents it, with round number and status flags, to the 7-segment display path. It sits between the button inputs and the DelayGen / onekhz / BCD counter datapath.

---
 rtl/reaction_round_ctrl.sv | 148 ++++++++++++++
 tb/tb_reaction_round_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_round_ctrl.sv
// Session sequencer for the reaction-time tester: rounds, best time,
// fault/timeout flags, and delay-generator / BCD-counter control.
module reaction_round_ctrl #(
  parameter int ROUNDS  = 5,
  parameter int HOLD_MS = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       measure,
  input  logic       led,
  input  logic       tick,
  input  logic [3:0] q2,
  input  logic [3:0] q1,
  input  logic [3:0] q0,
  output logic       dly_start,
  output logic       cnt_clr,
  output logic       cnt_en,
  output logic [3:0] best2,
  output logic [3:0] best1,
  output logic [3:0] best0,
  output logic [3:0] round,
  output logic       error,
  output logic       timeout,
  output logic       done,
  output logic       busy
);

  localparam int HW = $clog2(HOLD_MS + 1);

  typedef enum logic [2:0] {
    IDLE, ARM, WAIT_LED, TIMING, HOLD, FAULT, FINISH
  } state_t;

  state_t        state_q, state_d;
  logic          start_q, meas_q;
  logic [11:0]   best_q, best_d;
  logic [3:0]    round_q, round_d;
  logic          error_q, error_d;
  logic          timeout_q, timeout_d;
  logic          done_q, done_d;
  logic [HW-1:0] hold_q, hold_d;

  logic [11:0] q;
  logic        q999, st_rise, ms_rise, hold_end;

  assign q        = {q2, q1, q0};
  assign q999     = (q == 12'h999);
  assign st_rise  = start & ~start_q;
  assign ms_rise  = measure & ~meas_q;
  assign hold_end = tick && (hold_q == HW'(HOLD_MS - 1));

  always_comb begin
    state_d   = state_q;
    best_d    = best_q;
    round_d   = round_q;
    error_d   = error_q;
    timeout_d = timeout_q;
    done_d    = done_q;
    hold_d    = hold_q;
    unique case (state_q)
      IDLE: ;
      ARM, WAIT_LED: begin
        if (ms_rise) begin
          state_d = FAULT;
          error_d = 1'b1;
        end else if (state_q == ARM) begin
          state_d = WAIT_LED;
        end else if (led) begin
          state_d = TIMING;
        end
      end
      TIMING: begin
        if (ms_rise) begin
          if (q < best_q) best_d = q;
          round_d = round_q + 4'd1;
          state_d = HOLD;
        end else if (tick && q999) begin
          timeout_d = 1'b1;
          round_d   = round_q + 4'd1;
          state_d   = HOLD;
        end
      end
      HOLD, FAULT: begin
        if (hold_end) begin
          hold_d = '0;
          if (state_q == HOLD && round_q == 4'(ROUNDS)) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            // Entering ARM starts a fresh attempt with clean flags
            state_d   = ARM;
            error_d   = 1'b0;
            timeout_d = 1'b0;
          end
        end else if (tick) begin
          hold_d = hold_q + HW'(1);
        end
      end
      FINISH: ;
      default: state_d = IDLE;
    endcase
    if (st_rise) begin
      state_d   = ARM;
      best_d    = 12'h999;
      round_d   = '0;
      error_d   = 1'b0;
      timeout_d = 1'b0;
      done_d    = 1'b0;
      hold_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      start_q   <= 1'b1;
      meas_q    <= 1'b1;
      best_q    <= 12'h999;
      round_q   <= '0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start;
      meas_q    <= measure;
      best_q    <= best_d;
      round_q   <= round_d;
      error_q   <= error_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
      hold_q    <= hold_d;
    end
  end

  assign dly_start = (state_q == ARM);
  assign cnt_clr   = (state_q == ARM);
  assign cnt_en    = (state_q == TIMING) & tick & ~q999;
  assign busy      = (state_q != IDLE) && (state_q != FINISH);
  assign {best2, best1, best0} = best_q;
  assign round     = round_q;
  assign error     = error_q;
  assign timeout   = timeout_q;
  assign done      = done_q;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Bench for reaction_round_ctrl: BCD counter environment plus
// session-level reference expectations (min of recorded times).
module tb_reaction_round_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, measure, led, tick;
  logic [3:0] q2, q1, q0;
  logic       dly_start, cnt_clr, cnt_en;
  logic [3:0] best2, best1, best0, round;
  logic       error, timeout, done, busy;

  int cnt = 0;
  int dly_cnt = 0;
  int vectors = 0;
  int miscompares = 0;

  reaction_round_ctrl #(.ROUNDS(2), .HOLD_MS(3)) dut (
    .clk(clk), .reset(reset), .start(start), .measure(measure),
    .led(led), .tick(tick), .q2(q2), .q1(q1), .q0(q0),
    .dly_start(dly_start), .cnt_clr(cnt_clr), .cnt_en(cnt_en),
    .best2(best2), .best1(best1), .best0(best0), .round(round),
    .error(error), .timeout(timeout), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tick = ~tick;
    end
  end

  always @(posedge clk) begin
    if (cnt_clr) cnt <= 0;
    else if (cnt_en) cnt <= cnt + 1;
  end

  always @(negedge clk) if (dly_start) dly_cnt <= dly_cnt + 1;

  assign q2 = 4'(cnt / 100);
  assign q1 = 4'((cnt / 10) % 10);
  assign q0 = 4'(cnt % 10);

  function automatic logic [11:0] bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_dly(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (dly_start) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic play_round(input int react, input int led_dly,
                            output bit ok);
    wait_dly(ok);
    if (!ok) return;
    repeat (led_dly) step();
    led = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (cnt == react) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    measure = 1'b1;
    step();
    measure = 1'b0;
    led = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; measure = 1'b1; led = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %0h exp 0", busy); end
    vectors++; if ({best2, best1, best0} !== 12'h999) begin miscompares++; $display("FAIL rst_best got %0h exp 999", {best2, best1, best0}); end
    vectors++; if (round !== 4'd0) begin miscompares++; $display("FAIL rst_round got %0d exp 0", round); end
    vectors++; if ({error, timeout, done, dly_start, cnt_clr, cnt_en} !== 6'b0) begin miscompares++; $display("FAIL rst_flags got %b exp 000000", {error, timeout, done, dly_start, cnt_clr, cnt_en}); end
    measure = 1'b0;
    step();
    measure = 1'b1;
    step();
    measure = 1'b0;
    step();
    vectors++; if ({busy, error} !== 2'b00) begin miscompares++; $display("FAIL idle_press got %b exp 00", {busy, error}); end
  endtask

  task automatic test_two_rounds();
    bit ok;
    int d0;
    d0 = dly_cnt;
    pulse_start();
    vectors++; if ({dly_start, cnt_clr, busy} !== 3'b111) begin miscompares++; $display("FAIL arm_pulse got %b exp 111", {dly_start, cnt_clr, busy}); end
    play_round(123, 20, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL r1_bound got 0 exp 1"); end
    vectors++; if ({best2, best1, best0} !== bcd(123)) begin miscompares++; $display("FAIL r1_best got %0h exp 123", {best2, best1, best0}); end
    vectors++; if (round !== 4'd1) begin miscompares++; $display("FAIL r1_round got %0d exp 1", round); end
    play_round(87, 7, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL r2_bound got 0 exp 1"); end
    for (int i = 0; i < 50 && !done; i++) step();
    vectors++; if ({best2, best1, best0} !== bcd(87)) begin miscompares++; $display("FAIL two_best got %0h exp 087", {best2, best1, best0}); end
    vectors++; if ({round, done, busy} !== {4'd2, 2'b10}) begin miscompares++; $display("FAIL two_end got r%0d d%0h b%0h exp r2 d1 b0", round, done, busy); end
    vectors++; if (dly_cnt - d0 !== 2) begin miscompares++; $display("FAIL two_dly got %0d exp 2", dly_cnt - d0); end
  endtask

  task automatic test_fault();
    bit ok;
    pulse_start();
    repeat (3) step();
    measure = 1'b1;
    step();
    measure = 1'b0;
    vectors++; if ({error, busy, dly_start, round} !== {3'b110, 4'd0}) begin miscompares++; $display("FAIL early_press got e%0h b%0h d%0h r%0d exp e1 b1 d0 r0", error, busy, dly_start, round); end
    wait_dly(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL fault_exit got 0 exp 1"); end
    vectors++; if ({error, round} !== {1'b0, 4'd0}) begin miscompares++; $display("FAIL fault_rearm got e%0h r%0d exp e0 r0", error, round); end
    play_round(50, 4, ok);
    vectors++; if ({ok, error, round} !== {2'b10, 4'd1}) begin miscompares++; $display("FAIL after_fault got ok%0h e%0h r%0d exp ok1 e0 r1", ok, error, round); end
    vectors++; if ({best2, best1, best0} !== bcd(50)) begin miscompares++; $display("FAIL fault_best got %0h exp 050", {best2, best1, best0}); end
    wait_dly(ok);
    step(); step();
    led = 1'b1;
    measure = 1'b1;
    step();
    measure = 1'b0;
    led = 1'b0;
    vectors++; if ({ok, error, round} !== {2'b11, 4'd1}) begin miscompares++; $display("FAIL same_cycle got ok%0h e%0h r%0d exp ok1 e1 r1", ok, error, round); end
    wait_dly(ok);
    measure = 1'b1;
    step();
    measure = 1'b0;
    vectors++; if ({ok, error, round} !== {2'b11, 4'd1}) begin miscompares++; $display("FAIL arm_press got ok%0h e%0h r%0d exp ok1 e1 r1", ok, error, round); end
  endtask

  task automatic test_timeout();
    bit ok;
    bit en_bad;
    en_bad = 1'b0;
    pulse_start();
    wait_dly(ok);
    step();
    led = 1'b1;
    for (int i = 0; i < 2600 && !timeout; i++) begin
      if (cnt == 999 && tick && cnt_en) en_bad = 1'b1;
      step();
    end
    led = 1'b0;
    vectors++; if ({timeout, en_bad} !== 2'b10) begin miscompares++; $display("FAIL to_flag got t%0h en%0h exp t1 en0", timeout, en_bad); end
    vectors++; if (cnt !== 999) begin miscompares++; $display("FAIL to_cnt got %0d exp 999", cnt); end
    vectors++; if ({round, best2, best1, best0} !== {4'd1, 12'h999}) begin miscompares++; $display("FAIL to_state got r%0d b%0h exp r1 b999", round, {best2, best1, best0}); end
    wait_dly(ok);
    vectors++; if ({ok, timeout} !== 2'b10) begin miscompares++; $display("FAIL to_clear got ok%0h t%0h exp ok1 t0", ok, timeout); end
    step();
    led = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 2600; i++) begin
      if (cnt == 999 && tick) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    measure = 1'b1;
    step();
    measure = 1'b0;
    led = 1'b0;
    vectors++; if ({ok, timeout, round} !== {2'b10, 4'd2}) begin miscompares++; $display("FAIL press999 got ok%0h t%0h r%0d exp ok1 t0 r2", ok, timeout, round); end
    for (int i = 0; i < 50 && !done; i++) step();
    vectors++; if ({done, busy, best2, best1, best0} !== {2'b10, 12'h999}) begin miscompares++; $display("FAIL to_end got d%0h b%0h best%0h exp d1 b0 best999", done, busy, {best2, best1, best0}); end
  endtask

  task automatic test_restart();
    bit ok;
    pulse_start();
    play_round(250, 5, ok);
    vectors++; if ({ok, round, best2, best1, best0} !== {1'b1, 4'd1, bcd(250)}) begin miscompares++; $display("FAIL rs_pre got ok%0h r%0d b%0h exp ok1 r1 b250", ok, round, {best2, best1, best0}); end
    wait_dly(ok);
    step();
    led = 1'b1;
    for (int i = 0; i < 500 && cnt != 40; i++) step();
    start = 1'b1;
    step();
    start = 1'b0;
    led = 1'b0;
    vectors++; if ({dly_start, cnt_clr, round, best2, best1, best0} !== {2'b11, 4'd0, 12'h999}) begin miscompares++; $display("FAIL restart got d%0h c%0h r%0d b%0h exp d1 c1 r0 b999", dly_start, cnt_clr, round, {best2, best1, best0}); end
  endtask

  task automatic test_reset_mid();
    pulse_start();
    repeat (2) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    vectors++; if ({busy, dly_start, round, best2, best1, best0} !== {2'b00, 4'd0, 12'h999}) begin miscompares++; $display("FAIL mid_reset got b%0h d%0h r%0d best%0h exp b0 d0 r0 best999", busy, dly_start, round, {best2, best1, best0}); end
  endtask

  task automatic test_random_sessions();
    bit ok1, ok2;
    int r1, r2, exp_best, d0;
    for (int s = 0; s < 4; s++) begin
      r1 = $urandom_range(998, 1);
      r2 = $urandom_range(998, 1);
      exp_best = (r1 < r2) ? r1 : r2;
      d0 = dly_cnt;
      pulse_start();
      play_round(r1, $urandom_range(30, 2), ok1);
      play_round(r2, $urandom_range(30, 2), ok2);
      for (int i = 0; i < 50 && !done; i++) step();
      vectors++; if ({ok1, ok2, done, busy, round} !== {4'b1110, 4'd2}) begin miscompares++; $display("FAIL rnd%0d_end got ok%0h%0h d%0h b%0h r%0d exp ok11 d1 b0 r2", s, ok1, ok2, done, busy, round); end
      vectors++; if ({best2, best1, best0} !== bcd(exp_best)) begin miscompares++; $display("FAIL rnd%0d_best got %0h exp %0d", s, {best2, best1, best0}, exp_best); end
      vectors++; if (dly_cnt - d0 !== 2) begin miscompares++; $display("FAIL rnd%0d_dly got %0d exp 2", s, dly_cnt - d0); end
    end
  endtask

  initial begin
    test_reset();
    test_two_rounds();
    test_fault();
    test_timeout();
    test_restart();
    test_reset_mid();
    test_random_sessions();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
